// File: rtl/rx_pn_checker.sv
// Receive-side PN5/PN4 checker: self-synchronizing predictors with a HUNT/SYNC/LOCK
// acquisition FSM, windowed loss-of-lock detection and saturating bit/error statistics.
module rx_pn_checker #(
  parameter int BYTES    = 1,
  parameter int LOCK_THR = 16,
  parameter int WIN_LEN  = 64,
  parameter int ERR_LIM  = 8,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BYTES*8-1:0] data_tdata,
  input  logic               data_tvalid,
  output logic               data_tready,
  input  logic               data_tlast,
  input  logic               data_tuser,
  input  logic               clr_cnt,
  output logic               locked,
  output logic [CNT_W-1:0]   bit_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               err_pulse
);

  localparam int GW = $clog2(LOCK_THR + 1);
  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int EW = $clog2(ERR_LIM + 3);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [4:0]      r5;
  logic [3:0]      r4;
  logic [2:0]      fill, fill_nxt;
  logic [GW-1:0]   good, good_nxt;
  logic [WW-1:0]   win_cnt, win_cnt_nxt;
  logic [EW-1:0]   win_err, win_err_nxt;
  logic            last_user;
  logic            tready_q;
  logic            cnt_beat;

  logic            acc, b5, b4, p5, p4, mis5, mis4, any_mis, mode_chg, lost, win_end;
  logic [1:0]      mis_n;
  logic [EW-1:0]   win_sum;
  logic            unused_ok;

  assign unused_ok = ^{data_tdata, data_tlast};

  // Handshake: a beat transfers on a rising edge where data_tvalid and data_tready are both 1.
  assign acc      = data_tvalid & tready_q;
  assign b5       = data_tdata[1];
  assign b4       = data_tdata[0];
  assign p5       = r5[4] ^ r5[2];
  assign p4       = r4[3] ^ r4[2];
  assign mis5     = b5 ^ p5;
  assign mis4     = ~data_tuser & (b4 ^ p4);
  assign any_mis  = mis5 | mis4;
  assign mis_n    = {1'b0, mis5} + {1'b0, mis4};
  assign mode_chg = data_tuser != last_user;
  assign win_sum  = win_err + EW'(mis_n);
  assign lost     = win_sum >= EW'(ERR_LIM);
  assign win_end  = win_cnt == WW'(WIN_LEN - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    fill_nxt    = fill;
    good_nxt    = good;
    win_cnt_nxt = win_cnt;
    win_err_nxt = win_err;
    cnt_beat    = 1'b0;
    if (acc) begin
      if (mode_chg) begin
        // The mode-change beat is the first fill beat of a fresh hunt.
        state_nxt   = HUNT;
        fill_nxt    = 3'd1;
        good_nxt    = '0;
        win_cnt_nxt = '0;
        win_err_nxt = '0;
      end else begin
        case (state)
          HUNT: begin
            if (fill == 3'd4) begin
              state_nxt = SYNC;
              fill_nxt  = '0;
              good_nxt  = '0;
            end else begin
              fill_nxt = fill + 3'd1;
            end
          end
          SYNC: begin
            if (any_mis) begin
              good_nxt = '0;
            end else if (good == GW'(LOCK_THR - 1)) begin
              state_nxt   = LOCK;
              good_nxt    = '0;
              win_cnt_nxt = '0;
              win_err_nxt = '0;
            end else begin
              good_nxt = good + GW'(1);
            end
          end
          LOCK: begin
            cnt_beat = 1'b1;
            if (lost) begin
              state_nxt   = HUNT;
              fill_nxt    = '0;
              win_cnt_nxt = '0;
              win_err_nxt = '0;
            end else if (win_end) begin
              win_cnt_nxt = '0;
              win_err_nxt = '0;
            end else begin
              win_cnt_nxt = win_cnt + WW'(1);
              win_err_nxt = win_sum;
            end
          end
          default: state_nxt = HUNT;
        endcase
      end
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r5        <= '0;
      r4        <= '0;
      fill      <= '0;
      good      <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      last_user <= 1'b0;
      tready_q  <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      tready_q  <= 1'b1;
      err_pulse <= cnt_beat & any_mis;
      fill      <= fill_nxt;
      good      <= good_nxt;
      win_cnt   <= win_cnt_nxt;
      win_err   <= win_err_nxt;
      if (acc) begin
        last_user <= data_tuser;
        // Flywheel while locked so line errors never enter the predictors.
        if (state == LOCK && !mode_chg) begin
          r5 <= {r5[3:0], p5};
          r4 <= {r4[2:0], p4};
        end else begin
          r5 <= {r5[3:0], b5};
          r4 <= {r4[2:0], b4};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      bit_cnt <= '0;
      err_cnt <= '0;
    end else if (cnt_beat) begin
      bit_cnt <= sat_add(bit_cnt, data_tuser ? 2'd1 : 2'd2);
      err_cnt <= sat_add(err_cnt, mis_n);
    end
  end

  assign data_tready = tready_q;
  assign locked      = state == LOCK;

endmodule

// File: tb/tb_rx_pn_checker.sv
// Directed bench for rx_pn_checker: a 32-bit-counter instance and a 4-bit-counter
// instance share the same stimulus; expected values are hand-derived per step.
module tb_rx_pn_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  tdata;
  logic        tvalid, tlast, tuser, clr;
  logic        tready, locked, err_pulse;
  logic [31:0] bit_cnt, err_cnt;
  logic        tready4, locked4, err_pulse4;
  logic [3:0]  bit_cnt4, err_cnt4;
  logic [4:0]  g5;
  logic [3:0]  g4;
  int          checks = 0;
  int          failures = 0;
  int          n_acc;

  always #5 clk = ~clk;

  rx_pn_checker dut (
    .clk(clk), .rst_n(rst_n), .data_tdata(tdata), .data_tvalid(tvalid),
    .data_tready(tready), .data_tlast(tlast), .data_tuser(tuser), .clr_cnt(clr),
    .locked(locked), .bit_cnt(bit_cnt), .err_cnt(err_cnt), .err_pulse(err_pulse)
  );

  rx_pn_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .data_tdata(tdata), .data_tvalid(tvalid),
    .data_tready(tready4), .data_tlast(tlast), .data_tuser(tuser), .clr_cnt(clr),
    .locked(locked4), .bit_cnt(bit_cnt4), .err_cnt(err_cnt4), .err_pulse(err_pulse4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One accepted beat of the PN5 (bit1) / PN4 (bit0) streams, optionally corrupted.
  task automatic beat(input logic mode, input logic f5, input logic f4, input logic c);
    logic n5, n4;
    n5 = g5[4] ^ g5[2];
    n4 = g4[3] ^ g4[2];
    g5 = {g5[3:0], n5};
    g4 = {g4[2:0], n4};
    tdata  = {6'b0, n5 ^ f5, n4 ^ f4};
    tuser  = mode;
    tvalid = 1'b1;
    clr    = c;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    clr    = 1'b0;
  endtask

  task automatic beats(input logic mode, input int n);
    repeat (n) beat(mode, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; tdata = '0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; clr = 1'b0;
    g5 = 5'b11111; g4 = 4'b1111;
    idle(3);
    chk("rst_tready", {31'b0, tready}, 0);
    chk("rst_locked", {31'b0, locked}, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err_pulse", {31'b0, err_pulse}, 0);
    rst_n = 1'b1;
    idle(1);
    chk("tready_up", {31'b0, tready}, 1);

    // Clean BPSK acquisition: 5 fill + 16 good beats.
    beats(1'b1, 20);
    chk("s1_prelock", {31'b0, locked}, 0);
    beat(1'b1, 1'b0, 1'b0, 1'b0);
    chk("s1_lock", {31'b0, locked}, 1);
    chk("s1_bit_at_lock", bit_cnt, 0);
    beats(1'b1, 100);
    chk("s1_bit_100", bit_cnt, 100);
    chk("s1_err_0", err_cnt, 0);
    chk("s1_still_locked", {31'b0, locked}, 1);

    // QPSK switch forces reacquisition, then a single b4 error.
    beats(1'b0, 20);
    chk("s2_prelock", {31'b0, locked}, 0);
    chk("s2_bit_kept", bit_cnt, 100);
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    chk("s2_lock", {31'b0, locked}, 1);
    beats(1'b0, 3);
    chk("s2_bit_106", bit_cnt, 106);
    beat(1'b0, 1'b0, 1'b1, 1'b0);
    chk("s2_err_1", err_cnt, 1);
    chk("s2_pulse_hi", {31'b0, err_pulse}, 1);
    chk("s2_locked_hold", {31'b0, locked}, 1);
    chk("s2_bit_108", bit_cnt, 108);
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    chk("s2_pulse_lo", {31'b0, err_pulse}, 0);
    chk("s2_bit_110", bit_cnt, 110);

    // Finish the first 64-beat window, then 8 errors inside the next one.
    beats(1'b0, 59);
    chk("s3_bit_228", bit_cnt, 228);
    for (int i = 0; i < 7; i++) begin
      beat(1'b0, 1'b1, 1'b0, 1'b0);
      beat(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("s3_locked_7err", {31'b0, locked}, 1);
    chk("s3_err_8", err_cnt, 8);
    beat(1'b0, 1'b1, 1'b0, 1'b0);
    chk("s3_unlock", {31'b0, locked}, 0);
    chk("s3_err_9", err_cnt, 9);
    chk("s3_bit_258", bit_cnt, 258);
    chk("s3_pulse_last", {31'b0, err_pulse}, 1);
    beats(1'b0, 20);
    chk("s3_prelock", {31'b0, locked}, 0);
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    chk("s3_relock", {31'b0, locked}, 1);
    chk("s3_bit_kept", bit_cnt, 258);
    chk("s3_err_kept", err_cnt, 9);

    // Gapped valid: only accepted beats count.
    n_acc = 0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        beat(1'b0, 1'b0, 1'b0, 1'b0);
        n_acc++;
      end else begin
        idle(1);
      end
    end
    chk("s4_bit_gapped", bit_cnt, 258 + 2 * n_acc);
    chk("s4_err_gapped", err_cnt, 9);
    chk("s4_locked", {31'b0, locked}, 1);
    beat(1'b1, 1'b0, 1'b0, 1'b0);
    chk("s4_mode_unlock", {31'b0, locked}, 0);
    chk("s4_mode_not_counted", bit_cnt, 258 + 2 * n_acc);
    beats(1'b1, 19);
    chk("s4_prelock", {31'b0, locked}, 0);
    beat(1'b1, 1'b0, 1'b0, 1'b0);
    chk("s4_relock", {31'b0, locked}, 1);

    // 4-bit counter saturation and clear priority.
    beats(1'b0, 21);
    chk("s5_lock", {31'b0, locked4}, 1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    chk("s5_clr_bit", bit_cnt, 0);
    chk("s5_clr_bit4", {28'b0, bit_cnt4}, 0);
    chk("s5_clr_locked", {31'b0, locked}, 1);
    beats(1'b0, 7);
    chk("s5_bit4_14", {28'b0, bit_cnt4}, 14);
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    chk("s5_bit4_sat", {28'b0, bit_cnt4}, 15);
    chk("s5_bit_16", bit_cnt, 16);
    beats(1'b0, 2);
    chk("s5_bit4_hold", {28'b0, bit_cnt4}, 15);
    chk("s5_bit_20", bit_cnt, 20);
    chk("s5_err4_0", {28'b0, err_cnt4}, 0);
    beat(1'b0, 1'b0, 1'b0, 1'b1);
    chk("s5_clr_beat", bit_cnt, 0);
    chk("s5_clr_beat4", {28'b0, bit_cnt4}, 0);

    // One-cycle reset while locked.
    beats(1'b0, 1);
    beat(1'b0, 1'b1, 1'b0, 1'b0);
    chk("s6_pre_bit", bit_cnt, 4);
    chk("s6_pre_pulse", {31'b0, err_pulse}, 1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk("s6_rst_tready", {31'b0, tready}, 0);
    chk("s6_rst_locked", {31'b0, locked}, 0);
    chk("s6_rst_bit", bit_cnt, 0);
    chk("s6_rst_err", err_cnt, 0);
    chk("s6_rst_pulse", {31'b0, err_pulse}, 0);
    idle(1);
    chk("s6_tready_up", {31'b0, tready}, 1);
    beats(1'b0, 20);
    chk("s6_prelock", {31'b0, locked}, 0);
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    chk("s6_relock", {31'b0, locked}, 1);
    chk("s6_bit_0", bit_cnt, 0);
    beat(1'b0, 1'b0, 1'b0, 1'b0);
    chk("s6_bit_2", bit_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
